// File: rtl/pong_pkg.sv
// pong_pkg: constants and types shared by the Pong game FSM and the VGA renderer.
// Holds the 640x480@60 timing constants (800x525 total), sync windows, the
// net geometry, the colour constants and the 2-bit game-state encoding.
package pong_pkg;

  localparam int unsigned H_TOTAL      = 800;
  localparam int unsigned H_ACTIVE     = 640;
  localparam int unsigned H_SYNC_START = 656;
  localparam int unsigned H_SYNC_END   = 751;

  localparam int unsigned V_TOTAL      = 525;
  localparam int unsigned V_ACTIVE     = 480;
  localparam int unsigned V_SYNC_START = 490;
  localparam int unsigned V_SYNC_END   = 491;

  localparam int unsigned NET_X_LO     = 318;
  localparam int unsigned NET_X_HI     = 321;

  typedef enum logic [1:0] {
    GS_NEW_GAME = 2'd0,
    GS_PLAY     = 2'd1,
    GS_NEW_BALL = 2'd2,
    GS_OVER     = 2'd3
  } game_state_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t COL_BLACK = '{r: 4'h0, g: 4'h0, b: 4'h0};
  localparam rgb_t COL_WHITE = '{r: 4'hF, g: 4'hF, b: 4'hF};
  localparam rgb_t COL_NET   = '{r: 4'h8, g: 4'h8, b: 4'h8};
  localparam rgb_t COL_OVER  = '{r: 4'h4, g: 4'h0, b: 4'h0};

  // Half-open span test start <= pos < start+size, done in 11 bits so an
  // object near the bottom/right edge extends past 1023 instead of wrapping.
  function automatic logic in_span(input logic [10:0] pos,
                                   input logic [10:0] start,
                                   input logic [10:0] size);
    return (pos >= start) && (pos < start + size);
  endfunction

endpackage

// File: rtl/pong_vga_renderer_if.sv
// pong_vga_renderer_if: connection between the game side and the renderer.
//   ball_x, ball_y, paddle1, paddle2 : object positions (10 bits each)
//   game_state                       : 2-bit game FSM state (pong_pkg encoding)
//   frame_tick                       : one-clk pulse at start of vertical blank
//   hsync, vsync, red, green, blue   : VGA output
// master = game FSM / monitor side, slave = renderer.
interface pong_vga_renderer_if;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [9:0] paddle1;
  logic [9:0] paddle2;
  logic [1:0] game_state;
  logic       frame_tick;
  logic       hsync;
  logic       vsync;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;

  modport master (
    output ball_x, ball_y, paddle1, paddle2, game_state,
    input  frame_tick, hsync, vsync, red, green, blue
  );

  modport slave (
    input  ball_x, ball_y, paddle1, paddle2, game_state,
    output frame_tick, hsync, vsync, red, green, blue
  );
endinterface

// File: rtl/pong_vga_renderer_vga_timing.sv
// vga_timing: 25 MHz pixel enable from the 50 MHz clock, 800x525 h/v
// counters, raw (unregistered) active-low syncs, active-video flag and the
// once-per-frame latch strobe at h==0, v==480.
//   clk, rst    : 50 MHz clock, asynchronous active-low reset
//   pix_en      : high every other clk, first on the 2nd clk after release
//   h, v        : current pixel counters
//   hsync_raw, vsync_raw, active : decoded from h/v
//   frame_latch : pix_en cycle where h==0 and v==480
module vga_timing
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       active,
  output logic       frame_latch
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_en <= 1'b0;
      h      <= '0;
      v      <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (h == 10'(H_TOTAL - 1)) begin
          h <= '0;
          if (v == 10'(V_TOTAL - 1)) v <= '0;
          else                       v <= v + 10'd1;
        end else begin
          h <= h + 10'd1;
        end
      end
    end
  end

  always_comb begin
    hsync_raw   = !((h >= 10'(H_SYNC_START)) && (h <= 10'(H_SYNC_END)));
    vsync_raw   = !((v >= 10'(V_SYNC_START)) && (v <= 10'(V_SYNC_END)));
    active      = (h < 10'(H_ACTIVE)) && (v < 10'(V_ACTIVE));
    frame_latch = pix_en && (h == '0) && (v == 10'(V_ACTIVE));
  end

endmodule

// File: rtl/pong_vga_renderer.sv
// pong_vga_renderer: draws ball, two paddles, centre net and background on a
// 640x480 VGA raster. Game inputs are sampled into shadow registers once per
// frame (start of vertical blank) so a frame is always drawn from one
// consistent snapshot; frame_tick marks that same cycle for the game FSM.
//   clk, rst : 50 MHz clock, asynchronous active-low reset
//   bus      : slave side of pong_vga_renderer_if (game inputs in,
//              hsync/vsync/red/green/blue/frame_tick out)
// hsync, vsync and colour are registered together on pix_en, so the output
// for pixel (h,v) appears one pixel period after the counters show (h,v).
module pong_vga_renderer
  import pong_pkg::*;
#(
  parameter int unsigned BALL_SIZE = 8,
  parameter int unsigned PADDLE_W  = 8,
  parameter int unsigned PADDLE_H  = 64,
  parameter int unsigned P1_X      = 16,
  parameter int unsigned P2_X      = 616
) (
  input  logic              clk,
  input  logic              rst,
  pong_vga_renderer_if.slave bus
);

  logic       pix_en;
  logic [9:0] h;
  logic [9:0] v;
  logic       hsync_raw;
  logic       vsync_raw;
  logic       active;
  logic       frame_latch;

  vga_timing u_timing (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .h           (h),
    .v           (v),
    .hsync_raw   (hsync_raw),
    .vsync_raw   (vsync_raw),
    .active      (active),
    .frame_latch (frame_latch)
  );

  logic [9:0]  sh_ball_x;
  logic [9:0]  sh_ball_y;
  logic [9:0]  sh_paddle1;
  logic [9:0]  sh_paddle2;
  game_state_e sh_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_ball_x  <= '0;
      sh_ball_y  <= '0;
      sh_paddle1 <= '0;
      sh_paddle2 <= '0;
      sh_state   <= GS_NEW_GAME;
    end else if (frame_latch) begin
      sh_ball_x  <= bus.ball_x;
      sh_ball_y  <= bus.ball_y;
      sh_paddle1 <= bus.paddle1;
      sh_paddle2 <= bus.paddle2;
      sh_state   <= game_state_e'(bus.game_state);
    end
  end

  logic [10:0] h11;
  logic [10:0] v11;
  logic        ball_hit;
  logic        paddle_hit;
  logic        net_hit;
  rgb_t        pixel;

  always_comb begin
    h11 = {1'b0, h};
    v11 = {1'b0, v};

    ball_hit   = in_span(h11, {1'b0, sh_ball_x}, 11'(BALL_SIZE)) &&
                 in_span(v11, {1'b0, sh_ball_y}, 11'(BALL_SIZE));
    paddle_hit = (in_span(h11, 11'(P1_X), 11'(PADDLE_W)) &&
                  in_span(v11, {1'b0, sh_paddle1}, 11'(PADDLE_H))) ||
                 (in_span(h11, 11'(P2_X), 11'(PADDLE_W)) &&
                  in_span(v11, {1'b0, sh_paddle2}, 11'(PADDLE_H)));
    // Dashed net: 8 rows on, 8 rows off.
    net_hit    = (h >= 10'(NET_X_LO)) && (h <= 10'(NET_X_HI)) && !v[3];

    pixel = (sh_state == GS_OVER) ? COL_OVER : COL_BLACK;
    if (!active)         pixel = COL_BLACK;
    else if (ball_hit)   pixel = COL_WHITE;
    else if (paddle_hit) pixel = COL_WHITE;
    else if (net_hit)    pixel = COL_NET;
  end

  logic hsync_q;
  logic vsync_q;
  rgb_t rgb_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= COL_BLACK;
    end else if (pix_en) begin
      hsync_q <= hsync_raw;
      vsync_q <= vsync_raw;
      rgb_q   <= pixel;
    end
  end

  assign bus.hsync      = hsync_q;
  assign bus.vsync      = vsync_q;
  assign bus.red        = rgb_q.r;
  assign bus.green      = rgb_q.g;
  assign bus.blue       = rgb_q.b;
  assign bus.frame_tick = frame_latch;

endmodule

// File: tb/tb_pong_vga_renderer.sv
// tb_pong_vga_renderer: self-checking bench for pong_vga_renderer.
// The reference model derives the displayed pixel purely from the number of
// clock edges since reset release (two clks per pixel, 420000 pixels per
// frame) and from a snapshot of the inputs taken at the start of each
// vertical blank; literal probe pixels and timing constants pin the model.
module tb_pong_vga_renderer;

  localparam int FRAME_PIX = 800 * 525;
  localparam int LATCH_PIX = 800 * 480;
  localparam int NPROBES   = 31;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  pong_vga_renderer_if bus ();

  pong_vga_renderer #(
    .BALL_SIZE (8),
    .PADDLE_W  (8),
    .PADDLE_H  (64),
    .P1_X      (16),
    .P2_X      (616)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int f;
    int h;
    int v;
    int rgb;
  } probe_t;

  probe_t probes [NPROBES] = '{
    '{1, 100, 200, 'hFFF}, '{1, 108, 200, 'h000}, '{1, 107, 207, 'hFFF},
    '{1,  16, 113, 'hFFF}, '{1,  16, 114, 'h000}, '{1,  16,  50, 'hFFF},
    '{1, 616, 470, 'hFFF}, '{1, 623, 479, 'hFFF}, '{1, 616, 469, 'h000},
    '{1, 320,   0, 'h888}, '{1, 320,   8, 'h000}, '{1, 700, 100, 'h000},
    '{2, 100, 300, 'hFFF}, '{2, 107, 307, 'hFFF}, '{2, 300, 300, 'h000},
    '{2,   0, 300, 'h000},
    '{3, 300, 300, 'hFFF}, '{3, 100, 300, 'h400}, '{3,  16,   0, 'h400},
    '{3,  16,  39, 'h400}, '{3,   0,   0, 'h400}, '{3, 639, 479, 'h400},
    '{3, 640,   0, 'h000}, '{3,   0, 480, 'h000}, '{3, 320,   0, 'h888},
    '{3, 616, 470, 'hFFF},
    '{4, 319,   0, 'hFFF}, '{4, 325,   7, 'hFFF}, '{4, 326,   0, 'h000},
    '{4, 319,   8, 'h000}, '{4, 616,   0, 'h000}
  };

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
      if (mismatched >= 40) finish_run();
    end
  endtask

  function automatic int pixel_rgb(int h, int v, int bx, int by, int p1, int p2, int gs);
    if (h >= 640 || v >= 480) return 0;
    if (h >= bx && h < bx + 8 && v >= by && v < by + 8) return 'hFFF;
    if (h >= 16 && h < 24 && v >= p1 && v < p1 + 64) return 'hFFF;
    if (h >= 616 && h < 624 && v >= p2 && v < p2 + 64) return 'hFFF;
    if (h >= 318 && h <= 321 && (v / 8) % 2 == 0) return 'h888;
    return (gs == 3) ? 'h400 : 0;
  endfunction

  // Model state
  int   edges = 0;
  int   sbx, sby, sp1, sp2, sgs;
  logic exp_hs, exp_vs, exp_ft;
  int   exp_rgb;
  int   q, p, mh, mv, fr;
  int   probes_hit = 0;
  int   hs_low = 0;
  int   vs_low = 0;
  int   ticks[$];

  always @(negedge clk) begin
    if (!rst) begin
      edges = 0;
      sbx = 0; sby = 0; sp1 = 0; sp2 = 0; sgs = 0;
      exp_hs = 1'b1; exp_vs = 1'b1; exp_rgb = 0;
      exp_ft = 1'b0;
    end else begin
      edges++;
      if (edges % 2 == 0) begin
        q  = edges / 2 - 1;
        fr = q / FRAME_PIX;
        p  = q % FRAME_PIX;
        mh = p % 800;
        mv = p / 800;
        exp_hs  = !(mh >= 656 && mh <= 751);
        exp_vs  = !(mv >= 490 && mv <= 491);
        exp_rgb = pixel_rgb(mh, mv, sbx, sby, sp1, sp2, sgs);
        if (p == LATCH_PIX) begin
          sbx = int'(bus.ball_x);  sby = int'(bus.ball_y);
          sp1 = int'(bus.paddle1); sp2 = int'(bus.paddle2);
          sgs = int'(bus.game_state);
        end
      end
      exp_ft = (edges % 2 == 1) && (((edges - 1) / 2) % FRAME_PIX == LATCH_PIX);
    end

    check("pixel_out {hs,vs,rgb}", {18'd0, bus.hsync, bus.vsync, bus.red, bus.green, bus.blue},
          {18'd0, exp_hs, exp_vs, exp_rgb[11:0]});
    check("frame_tick", {31'd0, bus.frame_tick}, {31'd0, exp_ft});

    if (rst && edges >= 2 && edges % 2 == 0) begin
      for (int i = 0; i < NPROBES; i++) begin
        if (probes[i].f == fr && probes[i].h == mh && probes[i].v == mv) begin
          probes_hit++;
          check($sformatf("probe f%0d (%0d,%0d)", fr, mh, mv),
                {20'd0, bus.red, bus.green, bus.blue}, probes[i].rgb);
        end
      end
    end

    if (rst && bus.frame_tick) ticks.push_back(edges);
    if (ticks.size() == 1) begin
      if (!bus.hsync) hs_low++;
      if (!bus.vsync) vs_low++;
    end
  end

  task automatic wait_edges(input int target);
    for (int n = 0; edges < target; n++) begin
      if (n > 2_000_000) begin
        compared++;
        mismatched++;
        $display("FAIL wait_edges: got %0d required %0d", edges, target);
        finish_run();
      end
      @(negedge clk);
    end
    #2;
  endtask

  initial begin
    bus.ball_x     = 10'd100;
    bus.ball_y     = 10'd200;
    bus.paddle1    = 10'd50;
    bus.paddle2    = 10'd470;
    bus.game_state = 2'd0;

    repeat (3) @(negedge clk);
    #2 rst = 1'b1;

    // Run to h=300, v=100, then reset mid-frame.
    wait_edges(2 * (100 * 800 + 300));
    rst = 1'b0;
    #1;
    check("rst_hsync", {31'd0, bus.hsync}, 32'd1);
    check("rst_vsync", {31'd0, bus.vsync}, 32'd1);
    check("rst_rgb", {20'd0, bus.red, bus.green, bus.blue}, 32'd0);
    check("rst_frame_tick", {31'd0, bus.frame_tick}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    // Frame 0 -> tick 1 latches ball (100,200), paddles 50/470, state 0.
    wait_edges(2 * LATCH_PIX + 2);
    check("first_tick_edge", (ticks.size() > 0) ? ticks[0] : -1, 2 * 800 * 480 + 1);

    // Frame 1 row 10: ball moves to (100,300) for frame 2.
    wait_edges(2 * (FRAME_PIX + 10 * 800));
    bus.ball_y = 10'd300;

    // Frame 2 row 240: mid-frame changes must only show in frame 3.
    wait_edges(2 * (2 * FRAME_PIX + 240 * 800));
    bus.ball_x     = 10'd300;
    bus.paddle1    = 10'd1000;
    bus.game_state = 2'd3;

    // Frame 3 row 10: frame 4 has ball over the net.
    wait_edges(2 * (3 * FRAME_PIX + 10 * 800));
    bus.ball_x     = 10'd318;
    bus.ball_y     = 10'd0;
    bus.paddle1    = 10'd50;
    bus.game_state = 2'd0;

    wait_edges(2 * (4 * FRAME_PIX + 9 * 800));

    check("tick_count", ticks.size(), 4);
    check("tick_period_1", (ticks.size() > 1) ? ticks[1] - ticks[0] : -1, 840000);
    check("tick_period_2", (ticks.size() > 2) ? ticks[2] - ticks[1] : -1, 840000);
    check("hsync_low_clks_per_frame", hs_low, 96 * 525 * 2);
    check("vsync_low_clks_per_frame", vs_low, 2 * 800 * 2);
    check("probes_reached", probes_hit, NPROBES);

    finish_run();
  end

endmodule

// File: doc/pong_vga_renderer.md
PONG_VGA_RENDERER -- requirements
Module: pong_vga_renderer

Interface
REQ-001 SHALL have parameter BALL_SIZE, default 8, meaning ball square side in pixels.
REQ-002 SHALL have parameter PADDLE_W, default 8, meaning paddle width in pixels.
REQ-003 SHALL have parameter PADDLE_H, default 64, meaning paddle height in pixels.
REQ-004 SHALL have parameter P1_X, default 16, meaning left paddle leftmost column.
REQ-005 SHALL have parameter P2_X, default 616, meaning right paddle leftmost column.
REQ-006 SHALL have port clk  input  1  system clock, 50 MHz.
REQ-007 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-008 SHALL have port ball_x  input  10  ball left column from game FSM.
REQ-009 SHALL have port ball_y  input  10  ball top row from game FSM.
REQ-010 SHALL have port paddle1  input  10  left paddle top row.
REQ-011 SHALL have port paddle2  input  10  right paddle top row.
REQ-012 SHALL have port game_state  input  2  game FSM state (0 new_game, 1 play, 2 new_ball, 3 over).
REQ-013 SHALL have port hsync  output  1  VGA horizontal sync, active-low.
REQ-014 SHALL have port vsync  output  1  VGA vertical sync, active-low.
REQ-015 SHALL have port red, green, blue  output  4 each  pixel colour.
REQ-016 SHALL have port frame_tick  output  1  one-clk pulse at start of vertical blank; the game FSM advances positions on it.

Function
REQ-017 SHALL generate pixel enable pix_en toggling every clk (25 MHz), high on the second clk after reset release.
REQ-018 SHALL keep h counter 0..799 and v counter 0..524, advancing only on pix_en; h wraps 799->0 and increments v; v wraps 524->0 when h wraps.
REQ-019 SHALL derive raw hsync low for h in 656..751, raw vsync low for v in 490..491, active video for h<640 and v<480.
REQ-020 SHALL latch ball_x, ball_y, paddle1, paddle2, game_state into shadow registers on the pix_en cycle where h==0 and v==480; all drawing uses shadows only.
REQ-021 SHALL assert frame_tick for exactly one clk on that same latch cycle, once per 800x525 pixel frame.
REQ-022 SHALL treat input changes between latch cycles as invisible; a mid-frame change appears only in the next frame.
REQ-023 SHALL compute all coordinate+size extents in 11 bits so e.g. paddle1=1000 covers rows 1000..1063 with no wrap; off-screen parts clipped.
REQ-024 SHALL draw ball where ball_x<=h<ball_x+BALL_SIZE and ball_y<=v<ball_y+BALL_SIZE: colour F,F,F.
REQ-025 SHALL draw paddle n where Pn_X<=h<Pn_X+PADDLE_W and paddlen<=v<paddlen+PADDLE_H: colour F,F,F.
REQ-026 SHALL draw net where 318<=h<=321 and v[3]==0: colour 8,8,8.
REQ-027 SHALL use background 0,0,0, or 4,0,0 when shadow game_state==3.
REQ-028 SHALL apply priority ball > paddles > net > background; overlap shows the higher layer.
REQ-029 SHALL drive red/green/blue to 0 whenever outside active video, regardless of game_state.
REQ-030 SHALL register hsync, vsync and colour together: values for counter (h,v) appear one pix_en period later, all three aligned.

Reset
REQ-031 SHALL, while rst low, force h=0, v=0, pix_en phase 0, shadows 0, hsync=1, vsync=1, rgb=0, frame_tick=0.
REQ-032 SHALL, on reset asserted mid-frame, abort immediately and restart from h=0, v=0 after release; no partial frame_tick.

Structure
REQ-033 SHALL take the 800/525 timing constants, sync windows, colour constants and the 2-bit game-state encoding from shared package pong_pkg, also used by the game FSM.
REQ-034 SHALL contain one sub-module vga_timing (pix_en, h/v counters, raw syncs, active flag, frame latch strobe); drawing logic stays in pong_vga_renderer.

Verification
REQ-035 SHALL verify timing: free-run 2 frames -> hsync low 96 pixel periods per 800, vsync low 2 lines per 525, frame_tick every 840000 clk.
REQ-036 SHALL verify drawing: ball=(100,200), paddle1=50 -> pixel (100,200) F,F,F; (108,200) 0,0,0; (16,113) F,F,F; (16,114) 0,0,0.
REQ-037 SHALL verify latch: change ball_x 100->300 at v=240 -> remainder of frame still draws at 100; next frame at 300.
REQ-038 SHALL verify priority/clipping: ball=(318,0) -> (319,0) F,F,F not net; paddle2=470 -> rows 470..479 drawn, no wrap at row 0.
REQ-039 SHALL verify state colour: game_state=3 latched -> background 4,0,0 in active area, 0,0,0 in blanking.
REQ-040 SHALL verify reset: assert rst at h=300,v=100 -> outputs reset values immediately; after release first frame_tick 2*800*480+1 clk later.
